rf_wb_scheduler: RTL and testbench



---
 rtl/rf_wb_scheduler.sv | 165 ++++++++++++++++
 tb/tb_rf_wb_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler: shares the register-file write port between writeback and the MDU result FIFO
// and scoreboards outstanding MDU destinations. Optional starvation guard: RFSCHED_STARVE_EN.
module rf_wb_scheduler #(
  parameter int XLEN         = 32,
  parameter int MAX_PEND     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic            id_we,
  input  logic            id_mdu,
  output logic            stall_id,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            wb_hold,
  input  logic            mdu_valid,
  input  logic [4:0]      mdu_rd,
  input  logic [XLEN-1:0] mdu_data,
  output logic            mdu_ready,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  localparam int PW = $clog2(MAX_PEND + 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PEND);
  localparam logic [PW-1:0] PEND_ONE = PW'(1);
  localparam logic [PW-1:0] PEND_ZERO = PW'(0);

  if (MAX_PEND < 1 || STARVE_LIMIT < 1) begin : g_bad_cfg
    $error("rf_wb_scheduler: MAX_PEND and STARVE_LIMIT must be at least 1");
  end

  logic [31:0]     busy_r;
  logic [31:0]     busy_nxt_s;
  logic [31:0]     set_mask_s;
  logic [31:0]     clr_mask_s;
  logic [PW-1:0]   pend_r;
  logic [4:0]      fifo_rd_r   [0:1];
  logic [XLEN-1:0] fifo_data_r [0:1];
  logic            rd_ptr_r;
  logic            wr_ptr_r;
  logic [1:0]      count_r;
  logic            empty_s;
  logic            full_s;
  logic            push_s;
  logic            drain_s;
  logic            issue_s;
  logic            starve_s;
  logic            wb_active_s;
  logic [4:0]      head_rd_s;
  logic [XLEN-1:0] head_data_s;

  assign empty_s     = (count_r == 2'd0);
  assign full_s      = (count_r == 2'd2);
  assign mdu_ready   = ~full_s;
  assign push_s      = mdu_valid & ~full_s;
  assign head_rd_s   = fifo_rd_r[rd_ptr_r];
  assign head_data_s = fifo_data_r[rd_ptr_r];
  assign wb_active_s = wb_we & (wb_addr != 5'd0);
  assign drain_s     = ~empty_s & (~wb_active_s | starve_s);

  assign stall_id = id_valid & ((id_use_rs1 & busy_r[id_rs1]) |
                                (id_use_rs2 & busy_r[id_rs2]) |
                                (id_we & busy_r[id_rd]) |
                                (id_mdu & (pend_r == PEND_MAX)));
  assign issue_s  = id_valid & id_mdu & ~stall_id;

  // A set from this cycle's issue overrides a clear from this cycle's drain; x0 never busy.
  assign set_mask_s = issue_s ? (32'd1 << id_rd) : 32'd0;
  assign clr_mask_s = drain_s ? (32'd1 << head_rd_s) : 32'd0;
  assign busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;

`ifdef RFSCHED_STARVE_EN
  localparam int AW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW-1:0] AGE_MAX = AW'(STARVE_LIMIT);
  localparam logic [AW-1:0] AGE_ONE = AW'(1);
  logic [AW-1:0] age_r;

  assign starve_s = (age_r >= AGE_MAX);
  assign wb_hold  = drain_s & wb_active_s;

  // Head-of-FIFO wait counter, saturating at the starvation limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_r <= {AW{1'b0}};
    end else if (empty_s || drain_s) begin
      age_r <= {AW{1'b0}};
    end else if (age_r != AGE_MAX) begin
      age_r <= age_r + AGE_ONE;
    end else begin
      age_r <= age_r;
    end
  end
`else
  assign starve_s = 1'b0;
  assign wb_hold  = 1'b0;
`endif

  // Write-port mux: FIFO head when draining, otherwise pipeline writeback.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = wb_addr;
    rf_wdata = wb_data;
    if (drain_s) begin
      rf_we    = (head_rd_s != 5'd0);
      rf_waddr = head_rd_s;
      rf_wdata = head_data_s;
    end else begin
      rf_we    = wb_active_s;
      rf_waddr = wb_addr;
      rf_wdata = wb_data;
    end
  end

  // Scoreboard and in-flight counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 32'd0;
      pend_r <= PEND_ZERO;
    end else begin
      busy_r <= busy_nxt_s;
      case ({issue_s, drain_s})
        2'b10:   pend_r <= pend_r + PEND_ONE;
        2'b01:   pend_r <= (pend_r != PEND_ZERO) ? pend_r - PEND_ONE : pend_r;
        default: pend_r <= pend_r;
      endcase
    end
  end

  // Two-entry result FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r       <= 1'b0;
      wr_ptr_r       <= 1'b0;
      count_r        <= 2'd0;
      fifo_rd_r[0]   <= 5'd0;
      fifo_rd_r[1]   <= 5'd0;
      fifo_data_r[0] <= {XLEN{1'b0}};
      fifo_data_r[1] <= {XLEN{1'b0}};
    end else begin
      if (push_s) begin
        fifo_rd_r[wr_ptr_r]   <= mdu_rd;
        fifo_data_r[wr_ptr_r] <= mdu_data;
        wr_ptr_r              <= ~wr_ptr_r;
      end
      if (drain_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, drain_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Self-checking bench for rf_wb_scheduler: hazard/writeback vector table, MDU result
// scoreboard, and hand-written multi-cycle sequences.
module tb_rf_wb_scheduler;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid, id_use_rs1, id_use_rs2, id_we, id_mdu;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic            stall_id;
  logic            wb_we;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            wb_hold;
  logic            mdu_valid;
  logic [4:0]      mdu_rd;
  logic [XLEN-1:0] mdu_data;
  logic            mdu_ready;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  rf_wb_scheduler #(.XLEN(XLEN), .MAX_PEND(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_we(id_we), .id_mdu(id_mdu),
    .stall_id(stall_id),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_hold(wb_hold),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } mdu_res_t;
  mdu_res_t sb_q[$];
  mdu_res_t e_v;

  typedef struct {
    logic        v;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, we;
    logic        wwe;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        exp_stall;
    logic        exp_rf_we;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_we = 1'b0; id_mdu = 1'b0;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_data = 32'd0;
  endtask

  task automatic issue_mdu(input logic [4:0] rd);
    id_valid = 1'b1; id_mdu = 1'b1; id_we = 1'b1; id_rd = rd;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    #1;
    chk("issue_no_stall", stall_id, 1'b0);
    tick();
    id_valid = 1'b0; id_mdu = 1'b0; id_we = 1'b0;
  endtask

  // Scoreboard: any port write not owed to the writeback stage must be the oldest MDU result.
  always @(negedge clk) begin
    if (!rst) begin
      if (rf_we && !(wb_we && wb_addr != 5'd0 && !wb_hold)) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_write: got addr %0d data 0x%0h, expected no MDU write", rf_waddr, rf_wdata);
        end else begin
          e_v = sb_q.pop_front();
          chk("sb_addr", {27'd0, rf_waddr}, {27'd0, e_v.rd});
          chk("sb_data", rf_wdata, e_v.data);
        end
      end
      if (mdu_valid && mdu_ready) sb_q.push_back({mdu_rd, mdu_data});
    end
  end

  initial begin
    vecs[0] = '{1'b0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3,  32'h0000_0033, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4,  32'h0000_0044, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 5'd0, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1,  32'h0000_0001, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 5'd6, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9,  32'h0000_9999, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 5'd1, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd2,  32'h0000_0002, 1'b1, 1'b0};

    set_idle();
    rst = 1'b1;
    id_valid = 1'b1; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    #2;
    chk("reset_mdu_ready", mdu_ready, 1'b1);
    chk("reset_rf_we", rf_we, 1'b0);
    chk("reset_wb_hold", wb_hold, 1'b0);
    chk("reset_stall", stall_id, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    set_idle();

    // Scoreboard x5 and x7 busy, then table of hazard / writeback vectors.
    issue_mdu(5'd5);
    issue_mdu(5'd7);
    for (int i = 0; i < 8; i++) begin
      id_valid = vecs[i].v; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; id_rd = vecs[i].rd;
      id_use_rs1 = vecs[i].u1; id_use_rs2 = vecs[i].u2; id_we = vecs[i].we; id_mdu = 1'b0;
      wb_we = vecs[i].wwe; wb_addr = vecs[i].waddr; wb_data = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d_stall", i), stall_id, vecs[i].exp_stall);
      chk($sformatf("vec%0d_rf_we", i), rf_we, vecs[i].exp_rf_we);
      chk($sformatf("vec%0d_hold", i), wb_hold, 1'b0);
      if (vecs[i].exp_rf_we) begin
        chk($sformatf("vec%0d_waddr", i), {27'd0, rf_waddr}, {27'd0, vecs[i].waddr});
        chk($sformatf("vec%0d_wdata", i), rf_wdata, vecs[i].wdata);
      end
      tick();
    end
    set_idle();

    // add x6,x5,x1 waits on the x5 result.
    id_valid = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd1; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    id_we = 1'b1; id_rd = 5'd6;
    for (int i = 0; i < 3; i++) begin
      #1; chk("raw_stall", stall_id, 1'b1); tick();
    end
    mdu_valid = 1'b1; mdu_rd = 5'd5; mdu_data = 32'hAAAA_0005;
    #1; chk("raw_offer_ready", mdu_ready, 1'b1); chk("raw_stall_offer", stall_id, 1'b1);
    tick();
    mdu_valid = 1'b0;
    #1;
    chk("raw_drain_we", rf_we, 1'b1);
    chk("raw_drain_addr", {27'd0, rf_waddr}, 32'd5);
    chk("raw_stall_drain", stall_id, 1'b1);
    tick();
    #1; chk("raw_stall_release", stall_id, 1'b0);
    set_idle();
    tick();

    // x7 = 0x1234 with writeback idle.
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h0000_1234;
    #1; tick();
    mdu_valid = 1'b0;
    #1;
    chk("x7_rf_we", rf_we, 1'b1);
    chk("x7_waddr", {27'd0, rf_waddr}, 32'd7);
    chk("x7_wdata", rf_wdata, 32'h0000_1234);
    tick();
    id_valid = 1'b1; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
    #1; chk("x7_busy_cleared", stall_id, 1'b0);
    set_idle();
    tick();

    // Queued x8 result under continuous writeback to x3.
    issue_mdu(5'd8);
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h3333_3333;
    mdu_valid = 1'b1; mdu_rd = 5'd8; mdu_data = 32'h0000_8888;
    #1; tick();
    mdu_valid = 1'b0;
`ifdef RFSCHED_STARVE_EN
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("starve_wait_addr", {27'd0, rf_waddr}, 32'd3);
      chk("starve_wait_hold", wb_hold, 1'b0);
      tick();
    end
    #1;
    chk("starve_force_hold", wb_hold, 1'b1);
    chk("starve_force_addr", {27'd0, rf_waddr}, 32'd8);
    chk("starve_force_we", rf_we, 1'b1);
    tick();
    #1;
    chk("starve_resume_addr", {27'd0, rf_waddr}, 32'd3);
    chk("starve_resume_hold", wb_hold, 1'b0);
    tick();
`else
    for (int i = 0; i < 12; i++) begin
      #1;
      chk("blocked_addr", {27'd0, rf_waddr}, 32'd3);
      chk("blocked_hold", wb_hold, 1'b0);
      tick();
    end
    wb_we = 1'b0;
    #1; chk("blocked_drain_addr", {27'd0, rf_waddr}, 32'd8);
    tick();
`endif
    set_idle();
    tick();

    // Four in flight, fifth MDU op stalls until the first drain.
    for (int r = 1; r <= 4; r++) issue_mdu(r[4:0]);
    id_valid = 1'b1; id_mdu = 1'b1; id_we = 1'b1; id_rd = 5'd10;
    #1; chk("pend_full_stall", stall_id, 1'b1); tick();
    #1; chk("pend_full_stall_hold", stall_id, 1'b1);
    mdu_valid = 1'b1; mdu_rd = 5'd1; mdu_data = 32'h0000_0011;
    tick();
    mdu_valid = 1'b0;
    #1;
    chk("pend_drain_addr", {27'd0, rf_waddr}, 32'd1);
    chk("pend_drain_stall", stall_id, 1'b1);
    tick();
    #1; chk("pend_release", stall_id, 1'b0);
    tick();
    set_idle();

    // Two results queued behind busy writeback; third offer is refused.
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_0033;
    mdu_valid = 1'b1; mdu_rd = 5'd2; mdu_data = 32'h0000_0022;
    #1; chk("fifo_ready_0", mdu_ready, 1'b1); tick();
    mdu_rd = 5'd3; mdu_data = 32'h0000_0333;
    #1; chk("fifo_ready_1", mdu_ready, 1'b1); tick();
    mdu_rd = 5'd4; mdu_data = 32'h0000_0044;
    #1; chk("fifo_full_ready", mdu_ready, 1'b0); tick();
    wb_we = 1'b0;
    #1;
    chk("fifo_full_drain_ready", mdu_ready, 1'b0);
    chk("fifo_drain_addr", {27'd0, rf_waddr}, 32'd2);
    tick();
    #1; chk("ready_after_drain", mdu_ready, 1'b1); tick();
    mdu_valid = 1'b0;
    #1; chk("fifo_last_addr", {27'd0, rf_waddr}, 32'd4); tick();
    #1;
    chk("fifo_idle_we", rf_we, 1'b0);
    chk("sb_empty", sb_q.size(), 32'd0);
    tick();

    // Reset with two queued results and a non-empty scoreboard.
    issue_mdu(5'd11);
    issue_mdu(5'd12);
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_0033;
    mdu_valid = 1'b1; mdu_rd = 5'd10; mdu_data = 32'h0000_000A;
    tick();
    mdu_rd = 5'd11; mdu_data = 32'h0000_000B;
    tick();
    set_idle();
    rst = 1'b1;
    id_valid = 1'b1; id_rs1 = 5'd12; id_use_rs1 = 1'b1; id_rs2 = 5'd10; id_use_rs2 = 1'b1;
    #1;
    chk("rst_mid_rf_we", rf_we, 1'b0);
    chk("rst_mid_ready", mdu_ready, 1'b1);
    chk("rst_mid_busy", stall_id, 1'b0);
    sb_q.delete();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("post_rst_no_write", rf_we, 1'b0);
      chk("post_rst_no_stall", stall_id, 1'b0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
